mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the two-requester memory arbiter.
//
// Contents:
//   state_e       - arbiter FSM states (IDLE, ACCESS, RESP)
//   REQ_CPU       - requester index of the CPU data port (0)
//   REQ_LDR       - requester index of the loader/debug port (1)
//   NUM_REQ       - number of requesters
//   idx_to_onehot - converts a requester index into a one-hot vector
//
// Word widths come from the project-wide WORD_WIDTH define, normally
// provided by defs.vh. The fallback below lets the arbiter build on its own
// when defs.vh has not been pulled in ahead of this package.

`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;
  localparam int unsigned NUM_REQ = 2;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
    return NUM_REQ'(2'b01 << idx);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection for the two-requester arbiter.
//
// Ports:
//   req   in  2  request per requester (bit 0 = CPU, bit 1 = loader/debug)
//   last  in  1  index of the requester granted last (MEM_ARB_RR_EN only)
//   gnt   out 2  one-hot winner, all zero when nobody requests
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   - ties go to the requester that was not granted last
//   undefined - ties always go to the CPU; no last-winner input exists

module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_CPU] && req[REQ_LDR]) begin
`ifdef MEM_ARB_RR_EN
      // The pointer holds the last winner, so the other one goes next.
      gnt = idx_to_onehot(~last);
`else
      gnt[REQ_CPU] = 1'b1;
`endif
    end else begin
      // Zero or one requester: the request vector already is the grant.
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two requesters (CPU data, loader/debug) onto one
// single-ported memory with a combinational read path. One access is in
// flight at a time; a read returns its data two cycles after acceptance.
//
// Parameters:
//   AW  address width (default WORD_WIDTH)
//   DW  data width    (default WORD_WIDTH)
//
// Ports:
//   clk             in   1   clock, all logic on the rising edge
//   rst_n           in   1   asynchronous active-low reset
//   req[1:0]        in   2   request per requester (0 = CPU, 1 = loader)
//   we[1:0]         in   2   write enable per requester, valid with req
//   addr0, addr1    in   AW  request address per requester
//   wdata0, wdata1  in   DW  write data per requester
//   gnt[1:0]        out  2   one-hot grant; accept = req[i] && gnt[i]
//   rvalid[1:0]     out  2   one-hot read-data valid
//   rdata           out  DW  registered read data, held between reads
//   mem_addr        out  AW  memory address
//   mem_wdata       out  DW  memory write data
//   mem_we          out  1   memory write enable (one cycle per write)
//   mem_rdata       in   DW  memory read data (combinational)
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   - round-robin tie break using a last-winner pointer that
//               resets to the loader so the CPU wins the first tie
//   undefined - fixed priority, CPU always wins ties, no pointer

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = `WORD_WIDTH,
  parameter int DW = `WORD_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  logic          win_q, win_d;       // index of the requester in flight
  logic          wr_q, wr_d;         // in-flight access is a write
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_RR_EN
  logic          last_q, last_d;     // requester granted most recently
`endif

  logic [1:0]    pick_gnt;

  arb_pick u_arb_pick (
    .req  (req),
`ifdef MEM_ARB_RR_EN
    .last (last_q),
`endif
    .gnt  (pick_gnt)
  );

  // Next-state and request latching. All request fields are captured at
  // accept so the requester may change its inputs while the access runs.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_gnt != 2'b00) begin
          win_d   = pick_gnt[REQ_LDR];
          wr_d    = (win_d == REQ_LDR) ? we[REQ_LDR]    : we[REQ_CPU];
          addr_d  = (win_d == REQ_LDR) ? addr1          : addr0;
          wdata_d = (win_d == REQ_LDR) ? wdata1         : wdata0;
`ifdef MEM_ARB_RR_EN
          last_d  = win_d;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = IDLE;
        end else begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= REQ_CPU;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= REQ_LDR;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Grant is only offered from IDLE. It is also gated by rst_n so that a
  // request held high during reset never shows a grant on the port.
  assign gnt       = (rst_n && (state_q == IDLE)) ? pick_gnt : 2'b00;

  // Write strobe comes from registered state only, so an asynchronous reset
  // in the middle of ACCESS drops it before the next clock edge.
  assign mem_we    = (state_q == ACCESS) && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign rvalid    = (state_q == RESP) ? idx_to_onehot(win_q) : 2'b00;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Shared memory: combinational read, write on the rising edge.
  logic [DW-1:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    exp_gnt;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0]    who;
    logic [DW-1:0] data;
    int            cyc;
  } rexp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every read response and every memory write must match
  // the oldest outstanding expectation.
  always @(negedge clk) begin
    rexp_t re;
    wexp_t we_e;
    if (rvalid != 2'b00) begin
      if (rq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rvalid: got rvalid=%b rdata=%h, required no response", rvalid, rdata);
      end else begin
        re = rq.pop_front();
        chk("rvalid", 32'(rvalid), 32'(re.who));
        chk("rdata", 32'(rdata), 32'(re.data));
        chk("read_latency", cyc, re.cyc);
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got mem_we=1 addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        we_e = wq.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(we_e.addr));
        chk("write_data", 32'(mem_wdata), 32'(we_e.data));
      end
    end
  end

  // Drive a request and wait (bounded) for the grant; push the expectation
  // for the requester that should win.
  task automatic issue(input logic [1:0] r, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] exp_gnt, input logic [DW-1:0] exp_rd,
                       input bit push, output int tries);
    bit got;
    got   = 1'b0;
    tries = 0;
    while (!got && tries < 8) begin
      @(negedge clk);
      req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      #1;
      if (gnt != 2'b00) got = 1'b1;
      else tries++;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL gnt_timeout: got gnt=%b, required %b", gnt, exp_gnt);
    end else begin
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      if (push) begin
        if (exp_gnt[1] ? w[1] : w[0])
          wq.push_back('{exp_gnt[1] ? a1 : a0, exp_gnt[1] ? d1 : d0});
        else
          rq.push_back('{exp_gnt, exp_rd, cyc + 2});
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req = 2'b00;
    we  = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_rdata"}, 32'(rdata), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [8];
    logic [1:0] order [4];
    int         tries;

    vecs[0] = '{2'b10, 2'b10, 16'h0000, 16'h0020, 16'h0000, 16'h1234, 2'b10, 16'h0000};
    vecs[1] = '{2'b01, 2'b00, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 2'b01, 16'h1234};
    vecs[2] = '{2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 16'hBEEF};
    vecs[3] = '{2'b10, 2'b00, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 2'b10, 16'hBEEF};
    vecs[4] = '{2'b01, 2'b01, 16'h0021, 16'h0000, 16'h00FF, 16'h0000, 2'b01, 16'h0000};
    vecs[5] = '{2'b10, 2'b00, 16'h0000, 16'h0021, 16'h0000, 16'h0000, 2'b10, 16'h00FF};
    vecs[6] = '{2'b01, 2'b01, 16'h00FF, 16'h0000, 16'hFFFF, 16'h0000, 2'b01, 16'h0000};
    vecs[7] = '{2'b10, 2'b00, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 2'b10, 16'hFFFF};

`ifdef MEM_ARB_RR_EN
    order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    for (int i = 0; i < 256; i++) mem[i] <= '0;
    mem[8'h10] <= 16'hBEEF;
    mem[8'h30] <= 16'h3333;
    mem[8'h40] <= 16'h5555;

    // Reset with both requests held high: nothing may leak out.
    rst_n = 1'b0;
    req = 2'b11; we = 2'b11;
    addr0 = 16'h0010; addr1 = 16'h0020; wdata0 = 16'h1111; wdata1 = 16'h2222;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    req = 2'b00; we = 2'b00;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-access vectors, each from IDLE.
    foreach (vecs[i]) begin
      issue(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1,
            vecs[i].exp_gnt, vecs[i].exp_rdata, 1'b1, tries);
      chk("gnt_same_cycle", tries, 0);
      idle(3);
    end

    // Field change after accept must not disturb the in-flight read.
    issue(2'b01, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 2'b01, 16'hBEEF, 1'b1, tries);
    @(negedge clk);
    req = 2'b00; we = 2'b01; addr0 = 16'h0030; wdata0 = 16'h7777;
    repeat (3) @(negedge clk);
    we = 2'b00;
    chk("mem30_untouched", 32'(mem[8'h30]), 32'h3333);

    // Loader pulses a write request only while the FSM sits in RESP.
    issue(2'b01, 2'b00, 16'h0021, 16'h0000, 16'h0000, 16'h0000, 2'b01, 16'h00FF, 1'b1, tries);
    @(negedge clk);
    req = 2'b00; we = 2'b00;
    @(negedge clk);
    req = 2'b10; we = 2'b10; addr1 = 16'h0050; wdata1 = 16'h9999;
    #1;
    chk("gnt_in_resp", 32'(gnt), 32'h0);
    @(negedge clk);
    req = 2'b00; we = 2'b00;
    repeat (3) @(negedge clk);
    chk("mem50_untouched", 32'(mem[8'h50]), 32'h0);
    chk("rdata_hold", 32'(rdata), 32'h00FF);

    // Reset in the middle of a write: the write must be dropped.
    issue(2'b10, 2'b10, 16'h0000, 16'h0040, 16'h0000, 16'hAAAA, 2'b10, 16'h0000, 1'b0, tries);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    repeat (2) @(negedge clk);
    req = 2'b00; we = 2'b00;
    rst_n = 1'b1;
    chk("mem40_kept", 32'(mem[8'h40]), 32'h5555);

    // Persistent tie right after reset; the CPU must win the first one.
    for (int k = 0; k < 4; k++) begin
      issue(2'b11, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, order[k],
            (order[k] == 2'b01) ? 16'hBEEF : 16'h1234, 1'b1, tries);
    end
    idle(4);

    chk("reads_drained", rq.size(), 0);
    chk("writes_drained", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
